// File: rtl/multi_channel_oneshot.sv
// Per-channel request/done one-shot: a request arms a programmable delay, after which a sticky
// done flag is held until the channel is cleared. Channels are fully independent.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for a request; b=0, busy=0
// ST_ARMED | counting DELAY cycles; b=0, busy=1, request ignored
// ST_DONE  | sticky done; b=1, busy=0, waits for clear
module multi_channel_oneshot #(
    parameter int NUM_CH = 4,
    parameter int DELAY  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             a,
    input  logic [NUM_CH-1:0]             clear,
    output logic [NUM_CH-1:0]             b,
    output logic [NUM_CH-1:0]             busy,
    output logic [$clog2(NUM_CH+1)-1:0]   armed_count,
    output logic [NUM_CH-1:0]             done_pulse
);

    localparam int CNT_W = $clog2(DELAY + 1);
    localparam int ACW   = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e             state_q [NUM_CH];
    state_e             state_d [NUM_CH];
    logic [CNT_W-1:0]   cnt_q   [NUM_CH];
    logic [CNT_W-1:0]   cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]  pulse_q;
    logic [NUM_CH-1:0]  pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    // Clear has priority in every state, including the terminal-count edge.
    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    cnt_d[i] = '0;
                    if (a[i] && !clear[i]) begin
                        state_d[i] = ST_ARMED;
                        cnt_d[i]   = CNT_W'(DELAY);
                    end
                end
                ST_ARMED: begin
                    if (clear[i]) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_W'(1)) begin
                        state_d[i] = ST_DONE;
                        cnt_d[i]   = '0;
                        pulse_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    cnt_d[i] = '0;
                    if (clear[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Flags decode straight from state so an async reset zeroes them without waiting for a clock.
    always_comb begin
        b           = '0;
        busy        = '0;
        armed_count = '0;
        done_pulse  = pulse_q;
        for (int i = 0; i < NUM_CH; i++) begin
            b[i]        = (state_q[i] == ST_DONE);
            busy[i]     = (state_q[i] == ST_ARMED);
            armed_count = armed_count + ACW'(state_q[i] == ST_ARMED);
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sva
        a_arm_timing: assert property (@(posedge clk) disable iff (!rst_n || clear[gi])
            (a[gi] && state_q[gi] == ST_IDLE) |-> ##1 !b[gi] ##DELAY b[gi]);

        a_pulse_on_rise: assert property (@(posedge clk) disable iff (!rst_n)
            $rose(b[gi]) == done_pulse[gi]);

        m_clear_known: assume property (@(posedge clk) disable iff (!rst_n)
            !$isunknown(clear[gi]));

        c_round_trip: cover property (@(posedge clk) disable iff (!rst_n)
            (state_q[gi] == ST_IDLE && a[gi] && !clear[gi]) ##1 busy[gi]
            ##DELAY (b[gi] && clear[gi]) ##1 (state_q[gi] == ST_IDLE));
    end

endmodule
